// File: rtl/alu_pkg.sv
// Package: alu_pkg
// Purpose:
//   Shared definitions for the multi-cycle ALU: opcode values, FSM state
//   encoding, the chunk-index width helper and the opcode legality check.
// Configuration:
//   ALU_SUB_EN -- when defined, opcode 1 (SUB) is a legal operation;
//                 otherwise it is reported as illegal.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_AND, OP_OR, OP_XOR: legal = 1'b1;
`ifdef ALU_SUB_EN
      OP_SUB: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Module: chunk_adder
// Purpose:
//   Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
//   The multi-cycle ALU reuses this one slice for every chunk of the operands.
// Ports:
//   a, b      in   CHUNK  addend chunks
//   cin       in   1      carry into bit 0
//   sum       out  CHUNK  a + b + cin (low CHUNK bits)
//   cout      out  1      carry out of the top bit
//   c_msb_in  out  1      carry into the top bit (signed-overflow detection)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK - 1];

endmodule

// File: rtl/multicycle_alu.sv
// Module: multicycle_alu
// Purpose:
//   Multi-cycle ALU that processes WIDTH-bit operands CHUNK bits per clock,
//   least-significant chunk first, rippling the carry between chunks through
//   a single shared chunk_adder. Valid/ready handshakes on both sides.
// Parameters:
//   WIDTH  operand/result width (must be a multiple of CHUNK)
//   CHUNK  bits processed per cycle; WIDTH/CHUNK cycles per operation
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready high only when idle
//   op, a, b             opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR) and operands
//   out_valid / out_ready result handshake; out_valid high only when done
//   result               WIDTH-bit result, modulo 2^WIDTH
//   carry                ADD carry out, SUB no-borrow, 0 for logic ops
//   overflow             signed overflow for ADD/SUB, 0 otherwise
//   zero                 result == 0
//   err                  illegal opcode; result and other flags forced to 0
// Configuration:
//   ALU_SUB_EN -- defined: opcode 1 performs a - b; undefined: opcode 1 is
//                 illegal and the operand inverter / carry-in select is absent.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("multicycle_alu: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t state;
  state_t state_next;

  // Operands are held as arrays of chunks so the active chunk is a plain
  // index by the chunk counter.
  logic [NCHUNK-1:0][CHUNK-1:0] a_reg;
  logic [NCHUNK-1:0][CHUNK-1:0] b_reg;
  logic [NCHUNK-1:0][CHUNK-1:0] result_reg;
  logic [NCHUNK-1:0][CHUNK-1:0] result_merged;
  logic [2:0]                   op_reg;
  logic [IW-1:0]                idx;
  logic                         chain_carry;
  logic                         carry_reg;
  logic                         overflow_reg;
  logic                         zero_reg;
  logic                         err_reg;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] b_eff;
  logic [CHUNK-1:0] sum_chunk;
  logic [CHUNK-1:0] res_chunk;
  logic             add_cout;
  logic             add_c_msb_in;
  logic             is_arith;
  logic             last_chunk;
  logic             start_carry;

  assign a_chunk    = a_reg[idx];
  assign b_chunk    = b_reg[idx];
  assign last_chunk = (idx == LAST_IDX);
  assign is_arith   = (op_reg == OP_ADD) || (op_reg == OP_SUB);

  // Subtraction is a + ~b + 1: every chunk of b is inverted and the
  // carry chain is seeded with 1 on the accept edge.
`ifdef ALU_SUB_EN
  assign b_eff       = (op_reg == OP_SUB) ? ~b_chunk : b_chunk;
  assign start_carry = (op == OP_SUB);
`else
  assign b_eff       = b_chunk;
  assign start_carry = 1'b0;
`endif

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a        (a_chunk),
    .b        (b_eff),
    .cin      (chain_carry),
    .sum      (sum_chunk),
    .cout     (add_cout),
    .c_msb_in (add_c_msb_in)
  );

  // Logic ops share the same chunk slot as the adder output.
  always_comb begin
    res_chunk = sum_chunk;
    case (op_reg)
      OP_AND:  res_chunk = a_chunk & b_chunk;
      OP_OR:   res_chunk = a_chunk | b_chunk;
      OP_XOR:  res_chunk = a_chunk ^ b_chunk;
      default: res_chunk = sum_chunk;
    endcase
  end

  // The zero flag must see the full result including the chunk being
  // written on the final edge, so merge it in before comparing.
  always_comb begin
    result_merged      = result_reg;
    result_merged[idx] = res_chunk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An illegal opcode spends one pass-through cycle in RUN without touching
  // the datapath, which gives it a fixed one-cycle latency to DONE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (err_reg || last_chunk) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then fill one result chunk per
  // edge. Flags are only produced on the last chunk and then held until
  // the next accept, so DONE backpressure needs no extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= OP_ADD;
      idx          <= '0;
      chain_carry  <= 1'b0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            op_reg       <= op;
            idx          <= '0;
            chain_carry  <= start_carry;
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
            err_reg      <= ~op_legal(op);
          end
        end
        S_RUN: begin
          if (!err_reg) begin
            result_reg  <= result_merged;
            chain_carry <= add_cout;
            if (last_chunk) begin
              carry_reg    <= is_arith & add_cout;
              overflow_reg <= is_arith & (add_cout ^ add_c_msb_in);
              zero_reg     <= (result_merged == '0);
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result   = result_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;
  assign err      = err_reg;

endmodule
